mfe_result_streamer: RTL and testbench

- Drains the 128x128 median-filtered result memory after the filter engine deasserts its busy output.
- Sweeps the result memory in raster order with pipelined reads and emits one pixel per beat on a valid/ready stream.
- Flags row ends and frame end, and accumulates a frame checksum for host-side comparison.
- Sits between the result memory read port and the host/DMA interface.

---
 rtl/mfe_result_streamer.sv | 146 ++++++++++++++
 tb/tb_mfe_result_streamer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mfe_result_streamer.sv
// Drains the median-filter result memory in raster order after the engine finishes,
// streaming one pixel per beat with row/frame flags and a running frame checksum.
module mfe_result_streamer #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned AW    = 14,
  parameter int unsigned DW    = 8,
  parameter int unsigned SUM_W = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mfe_busy,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_rd,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  output logic             m_eol,
  output logic             m_last,
  input  logic             m_ready,
  output logic             active,
  output logic             done,
  output logic [SUM_W-1:0] checksum
);

  localparam int unsigned    COL_W     = $clog2(IMG_W);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic          busy_d;
  logic          trig;
  logic          start;
  logic          inflight;
  logic          rd_done;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] beat_idx;

  // Two-entry output FIFO; the head entry drives m_data directly.
  logic [DW-1:0] fifo_mem [2];
  logic          wr_sel;
  logic          rd_sel;
  logic [1:0]    occ;
  logic          push;
  logic          pop;
  logic [2:0]    credit;

  assign trig  = busy_d & ~mfe_busy;
  assign start = (state == S_IDLE) & trig;

  assign push    = inflight;
  assign m_valid = (occ != 2'd0);
  assign m_data  = fifo_mem[rd_sel];
  assign pop     = m_valid & m_ready;

  // A pop this cycle frees a slot in time for data returning two cycles later,
  // which is what sustains one beat per cycle through a two-entry FIFO.
  assign credit  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign mem_ren = (state == S_RUN) & ~rd_done & (credit < 3'd2);
  assign mem_addr = rd_ptr;

  assign m_eol  = m_valid & (beat_idx[COL_W-1:0] == LAST_COL);
  assign m_last = m_valid & (beat_idx == LAST_ADDR);

  assign active = (state == S_RUN);
  assign done   = (state == S_DONE);

  // NOTE: every register below uses non-blocking assignment so all state
  // updates on an edge see the same pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: state_nx is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (trig)             state_nx = S_RUN;
      S_RUN:  if (pop && m_last)    state_nx = S_DONE;
      S_DONE:                       state_nx = S_IDLE;
      default:                      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_d   <= 1'b0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      rd_done  <= 1'b0;
      beat_idx <= '0;
      checksum <= '0;
    end else begin
      busy_d   <= mfe_busy;
      inflight <= mem_ren;
      if (start) begin
        rd_ptr   <= '0;
        rd_done  <= 1'b0;
        beat_idx <= '0;
        checksum <= '0;
      end else begin
        // The pointer parks on the last address so mem_addr holds after the sweep.
        if (mem_ren) begin
          if (rd_ptr == LAST_ADDR) rd_done <= 1'b1;
          else                     rd_ptr  <= rd_ptr + 1'b1;
        end
        if (pop) begin
          beat_idx <= beat_idx + 1'b1;
          checksum <= checksum + SUM_W'(m_data);
        end
      end
    end
  end

  // NOTE: the FIFO storage is reset too (it is only two words) so that m_data
  // reads zero straight out of reset instead of an undefined value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      occ         <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_sel] <= mem_rd;
        wr_sel           <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mfe_result_streamer.sv
// Randomised bench for mfe_result_streamer: a frame-level model predicts every
// beat, flag, checksum and read address, with literal checks pinning key totals.
module tb_mfe_result_streamer;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int SUM_W = 22;
  localparam int NPIX  = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mfe_busy = 1'b0;
  logic             mem_ren;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_rd = '0;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic             m_eol;
  logic             m_last;
  logic             m_ready = 1'b1;
  logic             active;
  logic             done;
  logic [SUM_W-1:0] checksum;

  mfe_result_streamer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .reset(reset), .mfe_busy(mfe_busy),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .m_valid(m_valid), .m_data(m_data), .m_eol(m_eol), .m_last(m_last),
    .m_ready(m_ready), .active(active), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_arr [NPIX];

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  int     phase = 2;       // 0 idle expected, 1 frame in flight, 2 reset held
  bit     ready_always = 1'b1;
  int     trig_cyc;
  int     beat_k;
  int     reads_issued;
  int     last_hs_cyc;
  int     done_count;
  int     eol_cnt;
  int     last_cnt;
  int     first_valid_cyc;
  bit     seen_valid;
  bit     prev_stall;
  logic [DW-1:0] prev_data;
  logic   prev_eol, prev_last;
  longint sum_model;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    beat_k = 0; reads_issued = 0; last_hs_cyc = -1; done_count = 0;
    eol_cnt = 0; last_cnt = 0; first_valid_cyc = -1; seen_valid = 1'b0;
    prev_stall = 1'b0; sum_model = 0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory; returns junk when not read to expose mistimed captures.
  always @(posedge clk) begin
    if (mem_ren) mem_rd <= mem_arr[mem_addr];
    else         mem_rd <= 8'($urandom);
  end

  always @(posedge clk) begin
    #1;
    m_ready = ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // Single compare process against the frame model.
  always @(negedge clk) begin
    bit hs;
    hs = m_valid & m_ready;
    if (phase == 2) begin
      check("reset_flags", {m_valid, m_eol, m_last, mem_ren, active, done}, 6'b0);
      check("reset_data", m_data, 0);
      check("reset_addr", mem_addr, 0);
      check("reset_checksum", checksum, 0);
      prev_stall = 1'b0;
    end else if (phase == 0) begin
      check("idle_quiet", {m_valid, mem_ren, active, done}, 4'b0);
      prev_stall = 1'b0;
    end else if (cyc > trig_cyc) begin
      check("active", active, (last_hs_cyc < 0) || (cyc <= last_hs_cyc));
      check("done", done, (last_hs_cyc >= 0) && (cyc == last_hs_cyc + 1));
      if (done) done_count++;
      check("checksum_run", checksum, sum_model);
      if (prev_stall)
        check("stall_hold", {m_valid, m_data, m_eol, m_last}, {1'b1, prev_data, prev_eol, prev_last});
      if (m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_valid_cyc = cyc;
        check("first_valid_latency", cyc - trig_cyc, 3);
      end
      if (ready_always && seen_valid && beat_k < NPIX)
        check("no_bubble", m_valid, 1);
      if (beat_k >= NPIX) begin
        check("no_extra_beat", m_valid, 0);
      end else if (m_valid) begin
        check("beat_data", m_data, mem_arr[beat_k]);
        check("beat_eol", m_eol, (beat_k % IMG_W) == IMG_W - 1);
        check("beat_last", m_last, beat_k == NPIX - 1);
      end
      if (mem_ren) begin
        if (reads_issued == 0) check("first_ren_latency", cyc - trig_cyc, 1);
        check("ren_addr", mem_addr, reads_issued);
        check("ren_in_range", reads_issued < NPIX, 1);
        check("ren_credit", (reads_issued - beat_k - int'(hs)) <= 1, 1);
        reads_issued++;
      end
      if (hs && beat_k < NPIX) begin
        sum_model += mem_arr[beat_k];
        if (m_eol)  eol_cnt++;
        if (m_last) last_cnt++;
        if (beat_k == NPIX - 1) last_hs_cyc = cyc;
        beat_k++;
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      prev_eol   = m_eol;
      prev_last  = m_last;
    end
  end

  task automatic start_frame();
    mfe_busy = 1'b1;
    repeat (2) step();
    mfe_busy = 1'b0;
    trig_cyc = cyc;
    reset_model();
    phase = 1;
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int i = 0; i < budget && beat_k < target; i++) step();
    check("reach_beat", beat_k >= target, 1);
  endtask

  task automatic finish_frame(input longint exp_sum);
    for (int i = 0; i < 40000 && done_count == 0; i++) step();
    check("frame_timeout", done_count, 1);
    repeat (3) step();
    check("frame_beats", beat_k, NPIX);
    check("frame_done_once", done_count, 1);
    check("frame_eol_count", eol_cnt, IMG_H);
    check("frame_last_count", last_cnt, 1);
    check("frame_first_latency", first_valid_cyc - trig_cyc, 3);
    check("frame_checksum", checksum, exp_sum);
    phase = 0;
  endtask

  initial begin
    longint rand_sum;
    for (int i = 0; i < NPIX; i++) mem_arr[i] = 8'(i);
    repeat (3) step();
    reset = 1'b0;
    phase = 0;
    repeat (3) step();

    // Ramp frame, always ready.
    ready_always = 1'b1;
    start_frame();
    finish_frame(64'd2088960);

    // Same frame under random backpressure.
    ready_always = 1'b0;
    start_frame();
    finish_frame(64'd2088960);

    // All-0xFF frame: largest legal checksum.
    for (int i = 0; i < NPIX; i++) mem_arr[i] = 8'hFF;
    ready_always = 1'b1;
    start_frame();
    finish_frame(64'd4177920);

    // Reset in the middle of a frame with mfe_busy held low.
    for (int i = 0; i < NPIX; i++) mem_arr[i] = 8'($urandom);
    start_frame();
    wait_beats(5000, 20000);
    reset = 1'b1;
    phase = 2;
    #1;
    check("async_valid_drop", {m_valid, active, mem_ren}, 3'b0);
    repeat (2) step();
    reset = 1'b0;
    phase = 0;
    repeat (20) step();

    // Fresh frame with a spurious busy edge mid-run and busy high through DONE.
    rand_sum = 0;
    for (int i = 0; i < NPIX; i++) rand_sum += mem_arr[i];
    start_frame();
    wait_beats(3000, 20000);
    mfe_busy = 1'b1;
    step();
    mfe_busy = 1'b0;
    step();
    wait_beats(16300, 20000);
    mfe_busy = 1'b1;
    finish_frame(rand_sum);
    repeat (10) step();

    // Next falling edge starts a new frame; cut it short with reset.
    start_frame();
    wait_beats(200, 1000);
    reset = 1'b1;
    phase = 2;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
